// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage: write-back stage of the pipeline.
//   Selects write-back data from the MEM/WB register, commits it to a 32x32
//   GPR file and serves two combinational decode read ports with write-through
//   bypass. An overflowing instruction becomes a precise trap: its write is
//   suppressed, EPC is captured and a one-cycle flush is raised with the
//   redirect target. Retired instructions and taken exceptions are counted.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   Wr_ALUres/dout/pcadd4/instr/Rw/Overflow/MemtoReg/RegWr  MEM/WB inputs
//   ra1, ra2 / rd1, rd2 decode read addresses / combinational read data
//   exc_flush           registered one-cycle flush request
//   exc_target          trap handler address (constant EXC_VECTOR)
//   epc                 PC of the last trapping instruction
//   retire_cnt, exc_cnt retired-instruction and taken-exception counters
module wb_regfile_stage #(
  parameter logic [31:0] EXC_VECTOR = 32'h00004180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Wr_ALUres,
  input  logic [31:0] Wr_dout,
  input  logic [31:0] Wr_pcadd4,
  input  logic [31:0] Wr_instr,
  input  logic [4:0]  Wr_Rw,
  input  logic        Wr_Overflow,
  input  logic [1:0]  Wr_MemtoReg,
  input  logic        Wr_RegWr,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic        exc_flush,
  output logic [31:0] exc_target,
  output logic [31:0] epc,
  output logic [31:0] retire_cnt,
  output logic [15:0] exc_cnt
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned CNTW = 16;

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_exc_flush;
  logic [XLEN-1:0]   r_gpr [NREG];
  logic [XLEN-1:0]   r_epc;
  logic [XLEN-1:0]   r_retire_cnt;
  logic [CNTW-1:0]   r_exc_cnt;

  logic              w_valid;
  logic              w_trap;
  logic              w_retire;
  logic              w_we;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_rd1;
  logic [XLEN-1:0]   w_rd2;

  // Instructions arriving while the flush is in flight are squashed.
  assign w_valid  = (Wr_instr != '0) && (r_state == RUN);
  assign w_trap   = w_valid && Wr_Overflow;
  assign w_retire = w_valid && !Wr_Overflow;
  assign w_we     = w_retire && Wr_RegWr && (Wr_Rw != '0);

  // Write-back data select; encoding 3 aliases the ALU result.
  always_comb begin
    w_wdata = Wr_ALUres;
    case (Wr_MemtoReg)
      2'd1:    w_wdata = Wr_dout;
      2'd2:    w_wdata = Wr_pcadd4;
      default: w_wdata = Wr_ALUres;
    endcase
  end

  // Decode read ports with same-cycle write-through bypass.
  always_comb begin
    w_rd1 = r_gpr[ra1];
    if (ra1 == '0)                  w_rd1 = '0;
    else if (w_we && ra1 == Wr_Rw)  w_rd1 = w_wdata;
    w_rd2 = r_gpr[ra2];
    if (ra2 == '0)                  w_rd2 = '0;
    else if (w_we && ra2 == Wr_Rw)  w_rd2 = w_wdata;
  end

  // GPR file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) r_gpr[i] <= '0;
    end else if (w_we) begin
      r_gpr[Wr_Rw] <= w_wdata;
    end
  end

  // Trap FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_exc_flush <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_exc_flush <= (w_next_state == TRAP);
    end
  end

  // Trap FSM: TRAP lasts exactly one cycle, so the flush is a single pulse.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:     if (w_trap) w_next_state = TRAP;
      TRAP:    w_next_state = RUN;
      default: w_next_state = RUN;
    endcase
  end

  // EPC capture and performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_epc        <= '0;
      r_retire_cnt <= '0;
      r_exc_cnt    <= '0;
    end else begin
      if (w_trap) begin
        r_epc <= Wr_pcadd4 - XLEN'(4);
        if (r_exc_cnt != {CNTW{1'b1}}) r_exc_cnt <= r_exc_cnt + CNTW'(1);
      end
      if (w_retire) r_retire_cnt <= r_retire_cnt + XLEN'(1);
    end
  end

  assign rd1        = w_rd1;
  assign rd2        = w_rd2;
  assign exc_flush  = r_exc_flush;
  assign exc_target = EXC_VECTOR;
  assign epc        = r_epc;
  assign retire_cnt = r_retire_cnt;
  assign exc_cnt    = r_exc_cnt;

endmodule
